enco_pulse_gen: RTL and testbench

Quadrature encoder pulse generator: the transmit-side counterpart of the encoder speed-measurement block. Takes an 8-bit speed (A-channel pulses per gate window) and a direction, and emits evenly spaced quadrature A/B edges. Uses the same 2^WIN_LOG2-cycle gate window as the measurement prescaler, so looping `enc_a` back into the measurement block reads back `speed`. Used for motor-loop bring-up and closed-loop test without a physical motor.

---
 rtl/enco_pulse_gen.sv | 172 +++++++++++++++++
 tb/tb_enco_pulse_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/enco_pulse_gen.sv
// -----------------------------------------------------------------------------
// enco_pulse_gen
// Quadrature encoder pulse generator. Converts a requested A-channel pulse count
// per gate window (2^WIN_LOG2 clk1 cycles) into evenly spaced quadrature A/B
// edges, using the same gate window as the speed-measurement prescaler so a
// looped-back enc_a reads back the requested speed.
//
// Optional feature macro: ENCO_GEN_INDEX_EN
//   defined   : an index counter emits one enc_z strobe every INDEX_PPR A-rises
//   undefined : enc_z is tied low
//
// Parameters
//   WIN_LOG2  : log2 of the gate window length in clk1 cycles (10..24)
//   INDEX_PPR : A pulses per emulated revolution, index feature only (2..65535)
//
// Ports
//   clk1      : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   en        : step enable; low freezes A/B and clears the phase accumulator
//   speed     : requested A pulses per window, sampled at the window boundary
//   dir       : 1 = A leads B, 0 = B leads A, sampled with speed
//   enc_a     : quadrature channel A
//   enc_b     : quadrature channel B
//   pulse     : one-cycle strobe in the cycle enc_a becomes 1
//   win_start : one-cycle strobe in the first cycle of each window
//   enc_z     : one-cycle index strobe
// -----------------------------------------------------------------------------
module enco_pulse_gen #(
    parameter int unsigned WIN_LOG2  = 17,
    parameter int unsigned INDEX_PPR = 200
) (
    input  logic       clk1,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] speed,
    input  logic       dir,
    output logic       enc_a,
    output logic       enc_b,
    output logic       pulse,
    output logic       win_start,
    output logic       enc_z
);

    localparam int unsigned ACC_W = WIN_LOG2;
    localparam int unsigned SUM_W = WIN_LOG2 + 1;

    // Encoding equals {A,B}, so the state register drives the outputs directly
    typedef enum logic [1:0] {
        Q_00 = 2'b00,
        Q_10 = 2'b10,
        Q_11 = 2'b11,
        Q_01 = 2'b01
    } quad_t;

    logic [ACC_W-1:0] r_cnt;
    logic [7:0]       r_speed_q;
    logic             r_dir_q;
    logic             r_win_start;
    logic [ACC_W-1:0] r_acc;
    quad_t            r_quad;
    quad_t            w_quad_next;
    logic             r_pulse;

    logic             w_cnt_last;
    logic [SUM_W-1:0] w_inc;
    logic [SUM_W-1:0] w_sum;
    logic             w_carry;
    logic             w_step;
    logic             w_a_rise;

    // Free-running window counter; speed/dir are captured in its last cycle
    assign w_cnt_last = &r_cnt;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_speed_q   <= '0;
            r_dir_q     <= 1'b0;
            r_win_start <= 1'b0;
        end else begin
            r_cnt       <= r_cnt + ACC_W'(1);
            r_win_start <= w_cnt_last;
            if (w_cnt_last) begin
                r_speed_q <= speed;
                r_dir_q   <= dir;
            end
        end
    end

    // Phase accumulator: four carries per requested A pulse, spread over the window
    assign w_inc   = SUM_W'({r_speed_q, 2'b00});
    assign w_sum   = SUM_W'(r_acc) + w_inc;
    assign w_carry = w_sum[SUM_W-1];
    assign w_step  = en & w_carry;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (!en) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_sum[ACC_W-1:0];
        end
    end

    // Quadrature state register
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_quad <= Q_00;
        end else begin
            r_quad <= w_quad_next;
        end
    end

    // Quadrature next state: one Gray step per carry, direction from dir_q
    always_comb begin
        w_quad_next = r_quad;
        w_a_rise    = 1'b0;
        if (w_step) begin
            unique case (r_quad)
                Q_00:    w_quad_next = r_dir_q ? Q_10 : Q_01;
                Q_10:    w_quad_next = r_dir_q ? Q_11 : Q_00;
                Q_11:    w_quad_next = r_dir_q ? Q_01 : Q_10;
                Q_01:    w_quad_next = r_dir_q ? Q_00 : Q_11;
                default: w_quad_next = Q_00;
            endcase
            w_a_rise = ~r_quad[1] & w_quad_next[1];
        end
    end

    // A-rise strobe, aligned with the A/B update
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_a_rise;
        end
    end

`ifdef ENCO_GEN_INDEX_EN
    localparam logic [15:0] IDX_LAST = 16'(INDEX_PPR - 1);

    logic [15:0] r_idx_cnt;
    logic        r_enc_z;
    logic        w_idx_wrap;

    // Index counter advances on every A-rise regardless of direction
    assign w_idx_wrap = (r_idx_cnt == IDX_LAST);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_idx_cnt <= '0;
            r_enc_z   <= 1'b0;
        end else begin
            r_enc_z <= w_a_rise & w_idx_wrap;
            if (w_a_rise) begin
                r_idx_cnt <= w_idx_wrap ? 16'd0 : r_idx_cnt + 16'd1;
            end
        end
    end

    assign enc_z = r_enc_z;
`else
    assign enc_z = 1'b0;
`endif

    assign enc_a     = r_quad[1];
    assign enc_b     = r_quad[0];
    assign pulse     = r_pulse;
    assign win_start = r_win_start;

endmodule

// File: tb/tb_enco_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_enco_pulse_gen
// Bench for enco_pulse_gen with a 1024-cycle window and INDEX_PPR = 4. A
// position/phase reference model predicts all outputs every cycle; a table of
// whole-window scenarios checks step/pulse counts and first-step timing, and
// hand sequences cover async reset and the index strobe.
// -----------------------------------------------------------------------------
module tb_enco_pulse_gen;

    localparam int unsigned W   = 10;
    localparam int          WIN = 1 << W;
    localparam int          PPR = 4;
`ifdef ENCO_GEN_INDEX_EN
    localparam bit IDX_EN = 1'b1;
`else
    localparam bit IDX_EN = 1'b0;
`endif

    logic       clk1 = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] speed;
    logic       dir;
    logic       enc_a;
    logic       enc_b;
    logic       pulse;
    logic       win_start;
    logic       enc_z;

    enco_pulse_gen #(
        .WIN_LOG2  (W),
        .INDEX_PPR (PPR)
    ) dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .en        (en),
        .speed     (speed),
        .dir       (dir),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .pulse     (pulse),
        .win_start (win_start),
        .enc_z     (enc_z)
    );

    always #5 clk1 = ~clk1;

    // Reference model: position 0..3 maps to {A,B} = 00,10,11,01; total phase
    // since the last enable is kept as an unbounded integer, and a step is taken
    // whenever its quotient by the window length increases.
    typedef struct {
        int     cnt;
        int     spd;
        bit     dr;
        longint ph;
        int     pos;
        bit     pul;
        bit     ws;
        bit     z;
        int     idx;
    } m_t;

    typedef struct {
        int spd;
        bit dr;
        int gap_at;
        int gap_len;
        int steps;
        int pulses;
        int first;
    } row_t;

    m_t   m;
    row_t rows[7];
    int   total;
    int   bad;

    function automatic bit a_of(input int p);
        return (p == 1) || (p == 2);
    endfunction

    function automatic bit b_of(input int p);
        return (p == 2) || (p == 3);
    endfunction

    function automatic m_t model_next(input m_t cur, input bit e, input int s, input bit d);
        m_t     n;
        longint p2;
        int     np;
        n     = cur;
        n.pul = 1'b0;
        n.z   = 1'b0;
        if (e) begin
            p2 = cur.ph + longint'(4 * cur.spd);
            if ((p2 >> W) != (cur.ph >> W)) begin
                np = cur.dr ? (cur.pos + 1) % 4 : (cur.pos + 3) % 4;
                if (!a_of(cur.pos) && a_of(np)) begin
                    n.pul = 1'b1;
                    if (cur.idx == PPR - 1) begin
                        n.idx = 0;
                        n.z   = IDX_EN;
                    end else begin
                        n.idx = cur.idx + 1;
                    end
                end
                n.pos = np;
            end
            n.ph = p2;
        end else begin
            n.ph = 0;
        end
        n.ws = (cur.cnt == WIN - 1);
        if (n.ws) begin
            n.spd = s;
            n.dr  = d;
        end
        n.cnt = (cur.cnt + 1) % WIN;
        return n;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock: model steps on the rising edge, outputs compared on the falling edge
    task automatic tick();
        @(posedge clk1);
        if (rst_n) m = model_next(m, en, int'(speed), dir);
        @(negedge clk1);
        check("outputs{a,b,pulse,ws,z}",
              longint'({enc_a, enc_b, pulse, win_start, enc_z}),
              longint'({a_of(m.pos), b_of(m.pos), m.pul, m.ws, m.z}));
    endtask

    int          n;
    int          st;
    int          pu;
    int          fi;
    int          mb;
    int          zstray;
    longint      zm;
    logic [1:0]  pab;

    initial begin
        rows[0] = '{1,   1'b1, 0,   0,   4,    1,   256};
        rows[1] = '{255, 1'b1, 0,   0,   1020, 255, 2};
        rows[2] = '{3,   1'b1, 0,   0,   12,   3,   86};
        rows[3] = '{0,   1'b0, 0,   0,   0,    0,   -1};
        rows[4] = '{2,   1'b0, 0,   0,   8,    2,   128};
        rows[5] = '{8,   1'b1, 300, 100, 28,   7,   32};
        rows[6] = '{8,   1'b1, 0,   0,   32,   8,   16};

        total = 0;
        bad   = 0;
        m     = '{default: 0};
        rst_n = 1'b0;
        en    = 1'b1;
        speed = 8'(rows[0].spd);
        dir   = rows[0].dr;
        repeat (3) tick();
        rst_n = 1'b1;

        // First window after release runs with speed_q = 0
        n = 0;
        while (!win_start && n < WIN + 100) begin
            tick();
            n++;
        end
        check("first_win_start", longint'(win_start), 1);

        // Whole-window scenarios; the next row's speed/dir is driven mid-window
        for (int r = 0; r < 7; r++) begin
            st  = 0;
            pu  = 0;
            fi  = -1;
            mb  = 0;
            pab = {enc_a, enc_b};
            for (int i = 1; i <= WIN; i++) begin
                en = !(rows[r].gap_len > 0 && (i - 1) >= rows[r].gap_at &&
                       (i - 1) < rows[r].gap_at + rows[r].gap_len);
                if ((i - 1) == 512 && r < 6) begin
                    speed = 8'(rows[r + 1].spd);
                    dir   = rows[r + 1].dr;
                end
                tick();
                if ({enc_a, enc_b} != pab) begin
                    st++;
                    if (fi < 0) fi = i;
                    if (enc_a != pab[1] && enc_b != pab[0]) mb++;
                    pab = {enc_a, enc_b};
                end
                if (pulse) pu++;
            end
            en = 1'b1;
            check($sformatf("row%0d_steps", r), st, rows[r].steps);
            check($sformatf("row%0d_pulses", r), pu, rows[r].pulses);
            check($sformatf("row%0d_first_step", r), fi, rows[r].first);
            check($sformatf("row%0d_double_bit", r), mb, 0);
        end

        // Async reset between clocks while {A,B} = 11
        n = 0;
        while (!(enc_a && enc_b) && n < 2000) begin
            tick();
            n++;
        end
        check("reach_ab11", longint'({enc_a, enc_b}), 3);
        #2;
        rst_n = 1'b0;
        m     = '{default: 0};
        #1;
        check("async_reset_outputs", longint'({enc_a, enc_b, pulse, win_start, enc_z}), 0);
        speed = 8'd10;
        dir   = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        n  = 0;
        pu = 0;
        while (!win_start && n < WIN + 100) begin
            tick();
            n++;
            if (pulse) pu++;
        end
        check("release_to_win_start", n, WIN);
        check("pulse_before_win_start", pu, 0);

        // Index window: speed 10 from reset gives index on A-rises 4 and 8
        pu     = 0;
        zm     = 0;
        zstray = 0;
        for (int i = 1; i <= WIN; i++) begin
            tick();
            if (pulse) begin
                pu++;
                if (enc_z) zm = zm | (64'(1) << pu);
            end else if (enc_z) begin
                zstray++;
            end
        end
        check("index_pulses", pu, 10);
        check("index_z_mask", zm, IDX_EN ? 64'h110 : 64'h0);
        check("z_without_pulse", zstray, 0);

        // Randomized operation against the model
        for (int k = 0; k < 20 * WIN; k++) begin
            if ((k % WIN) == 100 || $urandom_range(0, 511) == 0) speed = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 511) == 0) dir = ~dir;
            if ($urandom_range(0, 299) == 0) en = ~en;
            tick();
        end
        en = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
